// File: rtl/lcd_defs.sv
// Shared definitions for the HD44780 hex display: command bytes, control-bus
// bit positions, top-level sequencer states and the hex-to-ASCII helper.
package lcd_defs;

    // HD44780 command bytes used by the init sequence and the refresh.
    localparam logic [7:0] LCD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_ADDR0    = 8'h80;  // set DDRAM address 0

    // Bit positions inside lcd_control.
    localparam int CTRL_E  = 2;
    localparam int CTRL_RS = 1;
    localparam int CTRL_RW = 0;

    // Nibble steps per phase: 4 bare init nibbles + 4 bytes, and 5 bytes per refresh.
    localparam int INIT_STEPS    = 12;
    localparam int REFRESH_STEPS = 10;

    typedef enum logic [1:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_REFRESH
    } top_state_t;

    // Uppercase ASCII for one hex digit: '0'..'9' are 0x30.., 'A'..'F' are 0x41..
    // (0x41 - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble on the 4-bit LCD bus: SETUP (1), PULSE (E_PULSE, E high),
// HOLD (1), then WAIT (wait_cycles). done pulses in the final cycle so the
// caller can start the next nibble back-to-back.
module lcd_nibble_tx
    import lcd_defs::*;
#(
    parameter int E_PULSE = 12
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [3:0]  nibble,
    input  logic        rs,
    input  logic [19:0] wait_cycles,
    output logic        done,
    output logic [3:0]  lcd_dataout,
    output logic [2:0]  lcd_control
);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD,
        TX_WAIT
    } tx_phase_t;

    tx_phase_t   phase_q, phase_d;
    logic [19:0] cnt_q;
    logic [19:0] wait_q;
    logic [3:0]  data_q;
    logic        rs_q;
    logic        load;

    // Last cycle of a transfer; a zero wait ends the transfer in HOLD.
    always_comb begin
        done = ((phase_q == TX_HOLD) && (wait_q == 20'd0)) ||
               ((phase_q == TX_WAIT) && (cnt_q == 20'd0));
        load = start && ((phase_q == TX_IDLE) || done);
    end

    // Next-phase decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        phase_d = phase_q;
        unique case (phase_q)
            TX_IDLE:  phase_d = TX_IDLE;
            TX_SETUP: phase_d = TX_PULSE;
            TX_PULSE: if (cnt_q == 20'd0) phase_d = TX_HOLD;
            TX_HOLD:  phase_d = (wait_q == 20'd0) ? TX_IDLE : TX_WAIT;
            TX_WAIT:  if (cnt_q == 20'd0) phase_d = TX_IDLE;
            default:  phase_d = TX_IDLE;
        endcase
        if (load) phase_d = TX_SETUP;
    end

    // Phase register, per-phase down-counter and latched bus values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            phase_q <= TX_IDLE;
            cnt_q   <= 20'd0;
            wait_q  <= 20'd0;
            data_q  <= 4'h0;
            rs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (load) begin
                data_q <= nibble;
                rs_q   <= rs;
                wait_q <= wait_cycles;
            end
            if (phase_q == TX_SETUP) begin
                cnt_q <= 20'(E_PULSE - 1);
            end else if (phase_q == TX_HOLD) begin
                cnt_q <= (wait_q == 20'd0) ? 20'd0 : wait_q - 20'd1;
            end else if (cnt_q != 20'd0) begin
                cnt_q <= cnt_q - 20'd1;
            end
        end
    end

    // Bus drive: data and RS hold their latched values from SETUP through HOLD.
    always_comb begin
        lcd_dataout          = data_q;
        lcd_control          = 3'b000;
        lcd_control[CTRL_E]  = (phase_q == TX_PULSE);
        lcd_control[CTRL_RS] = rs_q;
        lcd_control[CTRL_RW] = 1'b0;
    end

endmodule

// File: rtl/lcd_hex_display.sv
// Drives an HD44780 in 4-bit mode: power-up delay, init sequence, then shows
// the latest 16-bit value as four uppercase hex digits at DDRAM address 0.
// A one-deep pending buffer keeps updates that arrive while busy.
module lcd_hex_display
    import lcd_defs::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int INIT_WAIT      = 205000,
    parameter int E_PULSE        = 12,
    parameter int NIBBLE_GAP     = 50,
    parameter int CMD_WAIT       = 2000,
    parameter int CLEAR_WAIT     = 82000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        busy,
    output logic [3:0]  lcd_dataout,
    output logic [2:0]  lcd_control
);

    top_state_t  state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [19:0] pu_cnt_q;
    logic [15:0] shown_q;
    logic [15:0] pend_val_q;
    logic        pend_q;

    logic        tx_start, tx_done, take_data, reload;
    logic [3:0]  tx_nibble;
    logic        tx_rs;
    logic [19:0] tx_wait;
    logic [3:0]  k;
    logic [7:0]  cur_byte;

    // Top state and nibble-step registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_POWERUP;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Power-up delay counter, running only while in POWERUP.
    always_ff @(posedge clk) begin
        if (clear || (state_q != ST_POWERUP)) pu_cnt_q <= 20'd0;
        else                                  pu_cnt_q <= pu_cnt_q + 20'd1;
    end

    // Sequencer: advances one nibble step per transfer done and decides refresh follow-ups.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tx_start  = 1'b0;
        take_data = 1'b0;
        reload    = 1'b0;
        unique case (state_q)
            ST_POWERUP: begin
                if (pu_cnt_q == 20'(POWERUP_CYCLES - 1)) begin
                    state_d  = ST_INIT;
                    step_d   = 4'd0;
                    tx_start = 1'b1;
                end
            end
            ST_INIT: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (step_q == 4'(INIT_STEPS - 1)) begin
                        state_d = ST_REFRESH;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (data_valid) begin
                    take_data = 1'b1;
                    state_d   = ST_REFRESH;
                    step_d    = 4'd0;
                    tx_start  = 1'b1;
                end
            end
            ST_REFRESH: begin
                if (tx_done) begin
                    if (step_q == 4'(REFRESH_STEPS - 1)) begin
                        step_d = 4'd0;
                        // A strobe in this very cycle counts as pending and is the newest value.
                        if (pend_q || data_valid) begin
                            reload   = 1'b1;
                            tx_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        step_d   = step_q + 4'd1;
                        tx_start = 1'b1;
                    end
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    // Nibble, RS and wait for the step about to start (only used when tx_start is high).
    always_comb begin
        k         = 4'd0;
        cur_byte  = 8'h00;
        tx_nibble = 4'h0;
        tx_rs     = 1'b0;
        tx_wait   = 20'(CMD_WAIT);
        if ((state_d == ST_INIT) && (step_d < 4'd4)) begin
            tx_nibble = (step_d == 4'd3) ? 4'h2 : 4'h3;
            tx_wait   = 20'(INIT_WAIT);
        end else begin
            if (state_d == ST_INIT) begin
                k = step_d - 4'd4;
                unique case (k[2:1])
                    2'd0:    cur_byte = LCD_FUNC_SET;
                    2'd1:    cur_byte = LCD_DISP_ON;
                    2'd2:    cur_byte = LCD_ENTRY;
                    default: cur_byte = LCD_CLEAR;
                endcase
            end else begin
                k     = step_d;
                tx_rs = (k[3:1] != 3'd0);
                unique case (k[3:1])
                    3'd0:    cur_byte = LCD_ADDR0;
                    3'd1:    cur_byte = hex_ascii(shown_q[15:12]);
                    3'd2:    cur_byte = hex_ascii(shown_q[11:8]);
                    3'd3:    cur_byte = hex_ascii(shown_q[7:4]);
                    default: cur_byte = hex_ascii(shown_q[3:0]);
                endcase
            end
            tx_nibble = k[0] ? cur_byte[3:0] : cur_byte[7:4];
            if (!k[0])                                              tx_wait = 20'(NIBBLE_GAP);
            else if ((state_d == ST_INIT) && (cur_byte == LCD_CLEAR)) tx_wait = 20'(CLEAR_WAIT);
        end
    end

    // Shown value and one-deep pending buffer; the shown value only changes between refreshes.
    always_ff @(posedge clk) begin
        if (clear) begin
            shown_q    <= 16'h0000;
            pend_q     <= 1'b0;
            pend_val_q <= 16'h0000;
        end else if (take_data) begin
            shown_q <= data_in;
        end else if (reload) begin
            shown_q <= data_valid ? data_in : pend_val_q;
            pend_q  <= 1'b0;
        end else if (data_valid && busy) begin
            pend_q     <= 1'b1;
            pend_val_q <= data_in;
        end
    end

    // Busy everywhere except IDLE.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    lcd_nibble_tx #(
        .E_PULSE(E_PULSE)
    ) u_tx (
        .clk        (clk),
        .clear      (clear),
        .start      (tx_start),
        .nibble     (tx_nibble),
        .rs         (tx_rs),
        .wait_cycles(tx_wait),
        .done       (tx_done),
        .lcd_dataout(lcd_dataout),
        .lcd_control(lcd_control)
    );

endmodule
